// File: rtl/domesday_pkg.sv
// ---------------------------------------------------------------------------
// domesday_pkg
// Shared types and constants for the sample capture / USB transfer path.
//   sample_t      : 16-bit signed ADC sample
//   state_t       : capture FSM states (IDLE, RUN, FLUSH)
//   OVF_COUNT_MAX : saturation value of the lost-sample counter
// ---------------------------------------------------------------------------
package domesday_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [15:0] OVF_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sample_dpram.sv
// ---------------------------------------------------------------------------
// sample_dpram
// Simple dual-port RAM holding the buffered samples: one write port and one
// read port whose output is registered, so it maps onto block RAM.
// Ports:
//   inclk   : clock
//   wrEn    : write strobe, wrData stored at wrAddr
//   wrAddr  : write address
//   wrData  : sample to store
//   rdEn    : read strobe, rdData loads mem[rdAddr] on the next edge
//   rdAddr  : read address
//   rdData  : registered read data (holds when rdEn is low)
// ---------------------------------------------------------------------------
module sample_dpram
  import domesday_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  inclk,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  sample_t               wrData,
  input  logic                  rdEn,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output sample_t               rdData
);

  sample_t mem [0:(1<<ADDR_WIDTH)-1];

  // Write port. No reset on the array so the tools can map it to block RAM.
  always_ff @(posedge inclk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Registered read port; also left without reset to keep it inside the
  // block RAM primitive's output register.
  always_ff @(posedge inclk) begin
    if (rdEn) begin
      rdData <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/usb_sample_buffer.sv
// ---------------------------------------------------------------------------
// usb_sample_buffer
// Elastic FIFO between the sample source and the FX3 GPIF transfer logic.
// Pulls samples with a dataAvailable/readData handshake, buffers them in
// block RAM and offers them to the USB side as a pop interface with a
// watermark flag. Samples arriving while the buffer is full are counted
// as lost.
// Ports:
//   inclk         : sample clock, rising edge
//   nReset        : asynchronous active-low reset
//   collectData   : capture enable, low level flushes the buffer
//   dataAvailable : upstream has a valid sample on dataIn
//   dataIn        : upstream signed sample
//   readData      : upstream pop strobe, dataIn written on the same edge
//   usbRead       : USB-side pop request
//   usbData       : popped sample (registered)
//   usbDataValid  : usbData holds a freshly popped word this cycle
//   bufferReady   : fill level >= WATERMARK
//   bufferEmpty   : fill level == 0
//   overflow      : sticky, a sample was lost since capture started
//   overflowCount : lost-sample count, saturating
//                   (only with USB_SAMPLE_BUFFER_OVFCOUNT_EN defined)
// ---------------------------------------------------------------------------
module usb_sample_buffer
  import domesday_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WATERMARK  = 512
) (
  input  logic        inclk,
  input  logic        nReset,
  input  logic        collectData,
  input  logic        dataAvailable,
  input  logic [15:0] dataIn,
  output logic        readData,
  input  logic        usbRead,
  output logic [15:0] usbData,
  output logic        usbDataValid,
  output logic        bufferReady,
  output logic        bufferEmpty,
`ifdef USB_SAMPLE_BUFFER_OVFCOUNT_EN
  output logic [15:0] overflowCount,
`endif
  output logic        overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FILL_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   FILL_MARK = (ADDR_WIDTH+1)'(WATERMARK);
  localparam logic [ADDR_WIDTH:0]   FILL_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  state_t                state;
  state_t                nextState;
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic [ADDR_WIDTH:0]   fill;
  logic                  full;
  logic                  running;
  logic                  pop;
  logic                  popD1;
  logic                  lostSample;
  logic                  startCapture;
  sample_t               ramQ;

  assign full        = (fill == FILL_FULL);
  assign bufferEmpty = (fill == '0);
  assign bufferReady = (fill >= FILL_MARK);

  // Capture FSM state register.
  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake decode. Pops are gated only on RUN so a pop
  // requested in the cycle collectData drops still completes; writes need
  // collectData high as well so readData falls immediately.
  always_comb begin
    nextState    = state;
    running      = 1'b0;
    startCapture = 1'b0;
    unique case (state)
      IDLE: begin
        if (collectData) begin
          nextState    = RUN;
          startCapture = 1'b1;
        end
      end
      RUN: begin
        running = 1'b1;
        if (!collectData) begin
          nextState = FLUSH;
        end
      end
      FLUSH: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
    readData   = running & collectData & dataAvailable & ~full;
    lostSample = running & collectData & dataAvailable & full;
    pop        = running & usbRead & ~bufferEmpty;
  end

  // Pointers and fill level. FLUSH empties the buffer by clearing them;
  // a write and a pop in the same cycle leave the fill level unchanged.
  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      fill  <= '0;
    end else if (state == FLUSH) begin
      wrPtr <= '0;
      rdPtr <= '0;
      fill  <= '0;
    end else begin
      if (readData) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      if (readData && !pop) begin
        fill <= fill + FILL_ONE;
      end else if (pop && !readData) begin
        fill <= fill - FILL_ONE;
      end
    end
  end

  // Sticky overflow flag: cleared only when a new capture starts, so the
  // host can still see it after the buffer has been flushed.
  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      overflow <= 1'b0;
    end else if (startCapture) begin
      overflow <= 1'b0;
    end else if (lostSample) begin
      overflow <= 1'b1;
    end
  end

`ifdef USB_SAMPLE_BUFFER_OVFCOUNT_EN
  // Lost-sample counter, same clearing rule as the flag, saturating.
  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      overflowCount <= '0;
    end else if (startCapture) begin
      overflowCount <= '0;
    end else if (lostSample && (overflowCount != OVF_COUNT_MAX)) begin
      overflowCount <= overflowCount + 16'd1;
    end
  end
`else
`endif

  sample_dpram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) ram (
    .inclk (inclk),
    .wrEn  (readData),
    .wrAddr(wrPtr),
    .wrData(sample_t'(dataIn)),
    .rdEn  (pop),
    .rdAddr(rdPtr),
    .rdData(ramQ)
  );

  // Output stage: the RAM output register fills one cycle after the pop,
  // then usbData captures it. popD1 tracks which RAM words are fresh, so a
  // word already read out still produces its valid pulse after capture stops.
  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      popD1        <= 1'b0;
      usbDataValid <= 1'b0;
      usbData      <= '0;
    end else begin
      popD1        <= pop;
      usbDataValid <= popD1;
      if (popD1) begin
        usbData <= ramQ;
      end
    end
  end

endmodule

// File: tb/tb_usb_sample_buffer.sv
// ---------------------------------------------------------------------------
// tb_usb_sample_buffer
// Directed self-checking bench for usb_sample_buffer (ADDR_WIDTH=10,
// WATERMARK=512). Builds with or without USB_SAMPLE_BUFFER_OVFCOUNT_EN.
// ---------------------------------------------------------------------------
module tb_usb_sample_buffer;

  logic        inclk = 1'b0;
  logic        nReset = 1'b0;
  logic        collectData = 1'b0;
  logic        dataAvailable = 1'b0;
  logic [15:0] dataIn = '0;
  logic        usbRead = 1'b0;
  logic        readData;
  logic [15:0] usbData;
  logic        usbDataValid;
  logic        bufferReady;
  logic        bufferEmpty;
  logic        overflow;
`ifdef USB_SAMPLE_BUFFER_OVFCOUNT_EN
  logic [15:0] overflowCount;
`endif

  int checkCount = 0;
  int passCount  = 0;

  usb_sample_buffer #(
    .ADDR_WIDTH(10),
    .WATERMARK (512)
  ) dut (
    .inclk        (inclk),
    .nReset       (nReset),
    .collectData  (collectData),
    .dataAvailable(dataAvailable),
    .dataIn       (dataIn),
    .readData     (readData),
    .usbRead      (usbRead),
    .usbData      (usbData),
    .usbDataValid (usbDataValid),
    .bufferReady  (bufferReady),
    .bufferEmpty  (bufferEmpty),
`ifdef USB_SAMPLE_BUFFER_OVFCOUNT_EN
    .overflowCount(overflowCount),
`endif
    .overflow     (overflow)
  );

  // Free-running 100 MHz-style clock.
  always #5 inclk = ~inclk;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive all inputs at once (called between clock edges).
  task automatic applyStimulus(input logic collect, input logic avail,
                               input logic rd, input logic [15:0] din);
    collectData   = collect;
    dataAvailable = avail;
    usbRead       = rd;
    dataIn        = din;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  // Every output at its reset value.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".readData"}, 32'(readData), 32'd0);
    checkOutput({tag, ".usbData"}, 32'(usbData), 32'd0);
    checkOutput({tag, ".usbDataValid"}, 32'(usbDataValid), 32'd0);
    checkOutput({tag, ".bufferReady"}, 32'(bufferReady), 32'd0);
    checkOutput({tag, ".bufferEmpty"}, 32'(bufferEmpty), 32'd1);
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'd0);
`ifdef USB_SAMPLE_BUFFER_OVFCOUNT_EN
    checkOutput({tag, ".overflowCount"}, 32'(overflowCount), 32'd0);
`endif
  endtask

  initial begin
    // Reset values
    #12;
    checkResetValues("reset");
    tick();
    nReset = 1'b1;

    // First write: IDLE->RUN, then one sample
    applyStimulus(1, 0, 0, 16'd0);
    #1 checkOutput("idleNoRead", 32'(readData), 32'd0);
    tick();
    applyStimulus(1, 1, 0, 16'd0);
    #1 checkOutput("firstReadData", 32'(readData), 32'd1);
    checkOutput("emptyBeforeWrite", 32'(bufferEmpty), 32'd1);
    tick();
    applyStimulus(1, 0, 0, 16'd0);
    #1 checkOutput("readDataDrops", 32'(readData), 32'd0);
    checkOutput("emptyFalls", 32'(bufferEmpty), 32'd0);

    // Rest of the 512-sample ramp; watermark exactly at 512
    for (int i = 1; i < 512; i++) begin
      applyStimulus(1, 1, 0, 16'(i));
      #1;
      if (i == 511) checkOutput("readyAt511", 32'(bufferReady), 32'd0);
      tick();
    end
    applyStimulus(1, 0, 0, 16'd0);
    checkOutput("readyAt512", 32'(bufferReady), 32'd1);

    // 512 back-to-back pops, data 0..511 one cycle after each pop
    applyStimulus(1, 0, 1, 16'd0);
    for (int c = 0; c < 514; c++) begin
      tick();
      if (c == 511) applyStimulus(1, 0, 0, 16'd0);
      if (c >= 1 && c <= 512) begin
        checkOutput("rampValid", 32'(usbDataValid), 32'd1);
        checkOutput("rampData", 32'(usbData), 32'(c - 1));
      end else begin
        checkOutput("rampIdleValid", 32'(usbDataValid), 32'd0);
      end
    end
    checkOutput("drainedEmpty", 32'(bufferEmpty), 32'd1);
    checkOutput("drainedReady", 32'(bufferReady), 32'd0);

    // usbRead while empty is ignored
    applyStimulus(1, 0, 1, 16'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("emptyReadValid", 32'(usbDataValid), 32'd0);
      checkOutput("emptyReadEmpty", 32'(bufferEmpty), 32'd1);
    end

    // Fill to 1024
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(1, 1, 0, 16'(1000 + i));
      #1;
      if (i == 0 || i == 1023) checkOutput("fillReadData", 32'(readData), 32'd1);
      tick();
    end
    // Five lost samples
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 1, 0, 16'd0);
      #1 checkOutput("fullBlocked", 32'(readData), 32'd0);
      tick();
    end
    checkOutput("overflowSet", 32'(overflow), 32'd1);
    checkOutput("fullReady", 32'(bufferReady), 32'd1);
`ifdef USB_SAMPLE_BUFFER_OVFCOUNT_EN
    checkOutput("overflowCount5", 32'(overflowCount), 32'd5);
`endif
    // Pop at full while upstream offers data: write blocked, sample lost
    applyStimulus(1, 1, 1, 16'd7);
    #1 checkOutput("popAtFullRd", 32'(readData), 32'd0);
    tick();
    applyStimulus(1, 1, 0, 16'd2024);
    #1 checkOutput("refillRd", 32'(readData), 32'd1);
    tick();
    checkOutput("fullPopValid", 32'(usbDataValid), 32'd1);
    checkOutput("fullPopData", 32'(usbData), 32'd1000);
    applyStimulus(1, 1, 0, 16'd0);
    #1 checkOutput("fullAgainRd", 32'(readData), 32'd0);
`ifdef USB_SAMPLE_BUFFER_OVFCOUNT_EN
    checkOutput("overflowCount6", 32'(overflowCount), 32'd6);
`endif

    // Drop collectData: readData falls at once, FLUSH, overflow kept
    applyStimulus(0, 1, 0, 16'd0);
    #1 checkOutput("collectLowRd", 32'(readData), 32'd0);
    tick();
    tick();
    checkOutput("flushEmpty", 32'(bufferEmpty), 32'd1);
    checkOutput("flushReady", 32'(bufferReady), 32'd0);
    checkOutput("flushKeepsOvf", 32'(overflow), 32'd1);
`ifdef USB_SAMPLE_BUFFER_OVFCOUNT_EN
    checkOutput("flushKeepsCount", 32'(overflowCount), 32'd6);
`endif
    applyStimulus(1, 0, 0, 16'd0);
    tick();
    checkOutput("restartClearsOvf", 32'(overflow), 32'd0);
`ifdef USB_SAMPLE_BUFFER_OVFCOUNT_EN
    checkOutput("restartClearsCount", 32'(overflowCount), 32'd0);
`endif

    // Continuous write+pop at fill 1 for 2000 cycles (pointers wrap)
    applyStimulus(1, 1, 0, 16'd0);
    tick();
    for (int c = 0; c < 2000; c++) begin
      applyStimulus(1, 1, 1, 16'(c + 1));
      #1 checkOutput("streamRd", 32'(readData), 32'd1);
      checkOutput("streamEmpty", 32'(bufferEmpty), 32'd0);
      tick();
      if (c >= 1) begin
        checkOutput("streamValid", 32'(usbDataValid), 32'd1);
        checkOutput("streamData", 32'(usbData), 32'(c - 1));
      end
    end
    applyStimulus(1, 0, 0, 16'd0);
    tick();
    checkOutput("streamLastValid", 32'(usbDataValid), 32'd1);
    checkOutput("streamLastData", 32'(usbData), 32'd1999);
    tick();
    checkOutput("streamStopValid", 32'(usbDataValid), 32'd0);
    checkOutput("streamLeftOne", 32'(bufferEmpty), 32'd0);
    applyStimulus(1, 0, 1, 16'd0);
    tick();
    applyStimulus(1, 0, 0, 16'd0);
    tick();
    checkOutput("tailValid", 32'(usbDataValid), 32'd1);
    checkOutput("tailData", 32'(usbData), 32'd2000);
    checkOutput("tailEmpty", 32'(bufferEmpty), 32'd1);

    // Fill 300, then drop collectData mid-burst
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 1, 0, 16'(5000 + i));
      tick();
    end
    applyStimulus(1, 0, 1, 16'd0);
    tick();
    tick();
    checkOutput("burstData0", 32'(usbData), 32'd5000);
    applyStimulus(0, 0, 1, 16'd0);
    tick();
    checkOutput("burstData1", 32'(usbData), 32'd5001);
    tick();
    checkOutput("burstInFlightValid", 32'(usbDataValid), 32'd1);
    checkOutput("burstInFlightData", 32'(usbData), 32'd5002);
    checkOutput("burstFlushEmpty", 32'(bufferEmpty), 32'd1);
    tick();
    checkOutput("burstStopped", 32'(usbDataValid), 32'd0);

    // Reset mid-burst
    applyStimulus(1, 0, 0, 16'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 0, 16'(16'h8000 + i));
      tick();
    end
    applyStimulus(1, 1, 1, 16'h9000);
    tick();
    tick();
    tick();
    checkOutput("preResetValid", 32'(usbDataValid), 32'd1);
    checkOutput("preResetData", 32'(usbData), 32'h8001);
    #2 nReset = 1'b0;
    #1 checkResetValues("midReset");
    applyStimulus(0, 0, 0, 16'd0);
    tick();
    checkResetValues("heldReset");
    nReset = 1'b1;

    // Recovery after reset: a negative sample round trip
    applyStimulus(1, 0, 0, 16'd0);
    tick();
    applyStimulus(1, 1, 0, 16'h8000);
    tick();
    applyStimulus(1, 0, 1, 16'd0);
    tick();
    applyStimulus(1, 0, 0, 16'd0);
    tick();
    checkOutput("recoverValid", 32'(usbDataValid), 32'd1);
    checkOutput("recoverData", 32'(usbData), 32'h8000);
    checkOutput("recoverEmpty", 32'(bufferEmpty), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
